// File: rtl/fdiv_iter.sv
// fdiv_iter: iterative IEEE-754 single-precision divider / reciprocal unit.
// One operation in flight, valid/ready on both sides, restoring division
// producing BPC quotient bits per cycle, round-to-nearest-even, no denormals.
// Optional build macro FDIV_EXC_EN adds the exc[3:0] output
// {invalid, divzero, overflow, underflow}.
`timescale 1ns/1ps
`default_nettype none

module fdiv_iter #(
    parameter int ADD_W = 5,
    parameter int BPC   = 1     // quotient bits per DIV cycle: 1 or 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             inv_mode,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic             flagin,
    input  logic [ADD_W-1:0] addin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic             flagout,
    output logic [ADD_W-1:0] addout
`ifdef FDIV_EXC_EN
    ,
    output logic [3:0]       exc
`endif
);

    // 24 significand bits + guard + round
    localparam int QB    = 26;
    localparam int N_DIV = QB / BPC;
    localparam logic [4:0] CNT_LAST = 5'(N_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_DIV  = 3'd2,
        ST_RND  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t            state_r, state_nx_s;
    logic              accept_s;

    // operand capture
    logic              inv_r;
    logic [31:0]       x1_r, x2_r;
    logic              flag_r;
    logic [ADD_W-1:0]  add_r;

    // unpack / classify
    logic [31:0]       opa_s;
    logic              a_zero_s, a_inf_s, a_nan_s;
    logic              b_zero_s, b_inf_s, b_nan_s;
    logic              sign_s;
    logic [23:0]       m1_s, m2_s;
    logic              adj_s;
    logic [24:0]       num_s;
    logic signed [9:0] exp_pre_s;
    logic              spec_s;
    logic [31:0]       spec_y_s;

    // divider state
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [23:0]       div_r;
    logic [25:0]       rem_r, rem_nx_s, diff_s;
    logic [QB-1:0]     quo_r, quo_nx_s;
    logic [4:0]        cnt_r;
    logic              spec_r;
    logic [31:0]       spec_y_r;

    // rounding
    logic              sticky_s, rup_s;
    logic [24:0]       man_s;
    logic [22:0]       mant_s;
    logic signed [9:0] exp_rnd_s;
    logic [31:0]       y_rnd_s;

    // result registers
    logic              out_valid_r;
    logic [31:0]       y_r;

    assign in_ready  = (state_r == ST_IDLE) && !rst;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign flagout   = flag_r;
    assign addout    = add_r;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_PREP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PREP: state_nx_s = ST_DIV;
            ST_DIV: begin
                if (cnt_r == 5'd0) begin
                    state_nx_s = ST_RND;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            ST_RND:  state_nx_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // unpack operands, classify, pre-normalise the dividend
    always_comb begin
        opa_s     = inv_r ? 32'h3F80_0000 : x1_r;
        a_zero_s  = (opa_s[30:23] == 8'd0);
        a_inf_s   = (opa_s[30:23] == 8'hFF) && (opa_s[22:0] == 23'd0);
        a_nan_s   = (opa_s[30:23] == 8'hFF) && (opa_s[22:0] != 23'd0);
        b_zero_s  = (x2_r[30:23] == 8'd0);
        b_inf_s   = (x2_r[30:23] == 8'hFF) && (x2_r[22:0] == 23'd0);
        b_nan_s   = (x2_r[30:23] == 8'hFF) && (x2_r[22:0] != 23'd0);
        sign_s    = opa_s[31] ^ x2_r[31];
        m1_s      = {1'b1, opa_s[22:0]};
        m2_s      = {1'b1, x2_r[22:0]};
        // keep the quotient in [1,2) so bit QB-1 is always the hidden one
        adj_s     = (m1_s < m2_s);
        num_s     = adj_s ? {m1_s, 1'b0} : {1'b0, m1_s};
        exp_pre_s = {2'b00, opa_s[30:23]} - {2'b00, x2_r[30:23]} + 10'd127 - {9'd0, adj_s};
    end

    // special-operand results, forced in RND
    always_comb begin
        spec_s   = 1'b1;
        spec_y_s = 32'd0;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_y_s = 32'h7FC0_0000;
        end else if (b_zero_s || a_inf_s) begin
            spec_y_s = {sign_s, 8'hFF, 23'd0};
        end else if (b_inf_s || a_zero_s) begin
            spec_y_s = {sign_s, 31'd0};
        end else begin
            spec_s   = 1'b0;
            spec_y_s = 32'd0;
        end
    end

    // BPC restoring shift-subtract steps per cycle
    always_comb begin
        rem_nx_s = rem_r;
        quo_nx_s = quo_r;
        diff_s   = 26'd0;
        for (int i = 0; i < BPC; i++) begin
            diff_s = rem_nx_s - {2'b00, div_r};
            if (rem_nx_s >= {2'b00, div_r}) begin
                rem_nx_s = {diff_s[24:0], 1'b0};
                quo_nx_s = {quo_nx_s[QB-2:0], 1'b1};
            end else begin
                rem_nx_s = {rem_nx_s[24:0], 1'b0};
                quo_nx_s = {quo_nx_s[QB-2:0], 1'b0};
            end
        end
    end

    // round to nearest even, renormalise on carry, pack with overflow/flush
    always_comb begin
        sticky_s = |rem_r;
        rup_s    = quo_r[1] & (quo_r[0] | sticky_s | quo_r[2]);
        man_s    = {1'b0, quo_r[QB-1:2]} + {24'd0, rup_s};
        if (man_s[24]) begin
            mant_s    = man_s[23:1];
            exp_rnd_s = exp_r + 10'sd1;
        end else begin
            mant_s    = man_s[22:0];
            exp_rnd_s = exp_r;
        end
        if (spec_r) begin
            y_rnd_s = spec_y_r;
        end else if (exp_rnd_s >= 10'sd255) begin
            y_rnd_s = {sign_r, 8'hFF, 23'd0};
        end else if (exp_rnd_s <= 10'sd0) begin
            y_rnd_s = {sign_r, 31'd0};
        end else begin
            y_rnd_s = {sign_r, exp_rnd_s[7:0], mant_s};
        end
    end

    // operand capture, divider datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_r       <= 1'b0;
            x1_r        <= 32'd0;
            x2_r        <= 32'd0;
            flag_r      <= 1'b0;
            add_r       <= {ADD_W{1'b0}};
            sign_r      <= 1'b0;
            exp_r       <= 10'sd0;
            div_r       <= 24'd0;
            rem_r       <= 26'd0;
            quo_r       <= {QB{1'b0}};
            cnt_r       <= 5'd0;
            spec_r      <= 1'b0;
            spec_y_r    <= 32'd0;
            out_valid_r <= 1'b0;
            y_r         <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        inv_r  <= inv_mode;
                        x1_r   <= x1;
                        x2_r   <= x2;
                        flag_r <= flagin;
                        add_r  <= addin;
                    end
                end
                ST_PREP: begin
                    sign_r   <= sign_s;
                    exp_r    <= exp_pre_s;
                    div_r    <= m2_s;
                    rem_r    <= {1'b0, num_s};
                    quo_r    <= {QB{1'b0}};
                    cnt_r    <= CNT_LAST;
                    spec_r   <= spec_s;
                    spec_y_r <= spec_y_s;
                end
                ST_DIV: begin
                    rem_r <= rem_nx_s;
                    quo_r <= quo_nx_s;
                    cnt_r <= cnt_r - 5'd1;
                end
                ST_RND: begin
                    y_r         <= y_rnd_s;
                    out_valid_r <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef FDIV_EXC_EN
    logic [3:0] spec_exc_s, spec_exc_r, rnd_exc_s, exc_r;

    assign exc = exc_r;

    // exception flags for special operands
    always_comb begin
        spec_exc_s = 4'b0000;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_exc_s = 4'b1000;
        end else if (b_zero_s && !a_inf_s) begin
            spec_exc_s = 4'b0100;
        end else begin
            spec_exc_s = 4'b0000;
        end
    end

    // exception flags for the rounded finite result
    always_comb begin
        rnd_exc_s = 4'b0000;
        if (spec_r) begin
            rnd_exc_s = spec_exc_r;
        end else if (exp_rnd_s >= 10'sd255) begin
            rnd_exc_s = 4'b0010;
        end else if (exp_rnd_s <= 10'sd0) begin
            rnd_exc_s = 4'b0001;
        end else begin
            rnd_exc_s = 4'b0000;
        end
    end

    // exception registers, published together with y
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_exc_r <= 4'b0000;
            exc_r      <= 4'b0000;
        end else begin
            case (state_r)
                ST_PREP: spec_exc_r <= spec_exc_s;
                ST_RND:  exc_r      <= rnd_exc_s;
                default: begin
                    spec_exc_r <= spec_exc_r;
                end
            endcase
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fdiv_iter.sv
// tb_fdiv_iter: scoreboard bench for fdiv_iter, driving a BPC=1 and a BPC=2
// instance with the same operands.
`timescale 1ns/1ps

module tb_fdiv_iter;

    typedef struct packed {
        logic [31:0] y;
        logic        flag;
        logic [4:0]  add;
        logic [3:0]  exc;
    } exp_t;

    logic        clk, rst;
    logic        va, vb, rdy_a, rdy_b;
    logic        inv_mode, flagin;
    logic [31:0] x1, x2;
    logic [4:0]  addin;
    logic        ova, ovb, out_ready;
    logic [31:0] ya, yb;
    logic        fla, flb;
    logic [4:0]  ada, adb;
    logic [3:0]  exc_a, exc_b;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fdiv_iter #(.ADD_W(5), .BPC(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_ready(rdy_a), .inv_mode(inv_mode),
        .x1(x1), .x2(x2), .flagin(flagin), .addin(addin), .out_valid(ova),
        .out_ready(out_ready), .y(ya), .flagout(fla), .addout(ada)
`ifdef FDIV_EXC_EN
        , .exc(exc_a)
`endif
    );

    fdiv_iter #(.ADD_W(5), .BPC(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rdy_b), .inv_mode(inv_mode),
        .x1(x1), .x2(x2), .flagin(flagin), .addin(addin), .out_valid(ovb),
        .out_ready(out_ready), .y(yb), .flagout(flb), .addout(adb)
`ifdef FDIV_EXC_EN
        , .exc(exc_b)
`endif
    );

`ifndef FDIV_EXC_EN
    assign exc_a = 4'b0000;
    assign exc_b = 4'b0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer quotient, then round-to-nearest-even.
    function automatic exp_t model(input logic inv, input logic [31:0] a_in,
                                   input logic [31:0] b, input logic fl, input logic [4:0] ad);
        exp_t r;
        logic [31:0] a;
        logic sg, st, up;
        int ea, eb, e;
        longint unsigned ma, mb, num, q, rm, keep;
        logic [1:0] low;
        bit an, bn, az, bz, ai, bi;
        a  = inv ? 32'h3F80_0000 : a_in;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        az = (ea == 0);
        bz = (eb == 0);
        sg = a[31] ^ b[31];
        r.flag = fl;
        r.add  = ad;
        r.exc  = 4'b0000;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r.y = 32'h7FC0_0000; r.exc = 4'b1000; return r;
        end
        if (bz) begin
            r.y = {sg, 8'hFF, 23'd0}; r.exc = ai ? 4'b0000 : 4'b0100; return r;
        end
        if (ai) begin r.y = {sg, 8'hFF, 23'd0}; return r; end
        if (bi || az) begin r.y = {sg, 31'd0}; return r; end
        ma = 64'h80_0000 | 64'(a[22:0]);
        mb = 64'h80_0000 | 64'(b[22:0]);
        e  = ea - eb + 127;
        if (ma < mb) begin ma = ma << 1; e = e - 1; end
        num  = ma << 25;
        q    = num / mb;
        rm   = num % mb;
        low  = q[1:0];
        keep = q >> 2;
        st   = (rm != 64'd0);
        up   = (low == 2'b11) || ((low == 2'b10) && (st || keep[0]));
        keep = keep + 64'(up);
        if (keep == 64'h100_0000) begin keep = 64'h80_0000; e = e + 1; end
        if (e >= 255) begin
            r.y = {sg, 8'hFF, 23'd0}; r.exc = 4'b0010;
        end else if (e <= 0) begin
            r.y = {sg, 31'd0}; r.exc = 4'b0001;
        end else begin
            r.y = {sg, e[7:0], keep[22:0]};
        end
        return r;
    endfunction

    // Present one operation to both instances; each deasserts on its own accept.
    task automatic send(input logic inv, input logic [31:0] a, input logic [31:0] b,
                        input logic fl, input logic [4:0] ad, input exp_t e);
        logic acc_a, acc_b;
        inv_mode = inv; x1 = a; x2 = b; flagin = fl; addin = ad;
        qa.push_back(e);
        qb.push_back(e);
        va = 1'b1;
        vb = 1'b1;
        for (int k = 0; k < 200 && (va || vb); k++) begin
            @(negedge clk);
            acc_a = va && rdy_a;
            acc_b = vb && rdy_b;
            @(posedge clk);
            #1;
            if (acc_a) va = 1'b0;
            if (acc_b) vb = 1'b0;
        end
        if (va || vb) begin
            check_eq("send_timeout", {30'd0, va, vb}, 32'd0);
            va = 1'b0;
            vb = 1'b0;
        end
    endtask

    task automatic send_x(input logic inv, input logic [31:0] a, input logic [31:0] b,
                          input logic fl, input logic [4:0] ad,
                          input logic [31:0] ey, input logic [3:0] ee);
        exp_t e;
        e.y = ey; e.flag = fl; e.add = ad; e.exc = ee;
        send(inv, a, b, fl, ad, e);
    endtask

    task automatic send_m(input logic inv, input logic [31:0] a, input logic [31:0] b,
                          input logic fl, input logic [4:0] ad);
        send(inv, a, b, fl, ad, model(inv, a, b, fl, ad));
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clk);
        #1;
        check_eq("drain", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    task automatic lat_check(input int la, input int lb);
        int fa, fb;
        fa = 0;
        fb = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ova && fa == 0) fa = k;
            if (ovb && fb == 0) fb = k;
        end
        check_eq("lat_bpc1", 32'(fa), 32'(la));
        check_eq("lat_bpc2", 32'(fb), 32'(lb));
    endtask

    // scoreboard for the BPC=1 instance
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst && ova && out_ready) begin
            if (qa.size() == 0) begin
                check_eq("a_extra_out", 32'(ova), 32'd0);
            end else begin
                e = qa.pop_front();
                check_eq("a_y", ya, e.y);
                check_eq("a_flag", 32'(fla), 32'(e.flag));
                check_eq("a_add", 32'(ada), 32'(e.add));
`ifdef FDIV_EXC_EN
                check_eq("a_exc", 32'(exc_a), 32'(e.exc));
`endif
            end
        end
    end

    // scoreboard for the BPC=2 instance
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst && ovb && out_ready) begin
            if (qb.size() == 0) begin
                check_eq("b_extra_out", 32'(ovb), 32'd0);
            end else begin
                e = qb.pop_front();
                check_eq("b_y", yb, e.y);
                check_eq("b_flag", 32'(flb), 32'(e.flag));
                check_eq("b_add", 32'(adb), 32'(e.add));
`ifdef FDIV_EXC_EN
                check_eq("b_exc", 32'(exc_b), 32'(e.exc));
`endif
            end
        end
    end

    initial begin
        logic seen;
        logic [22:0] m;
        rst = 1'b1; va = 1'b0; vb = 1'b0; out_ready = 1'b1;
        inv_mode = 1'b0; x1 = 32'd0; x2 = 32'd0; flagin = 1'b0; addin = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, ova | ovb}, 32'd0);
        check_eq("rst_y", ya | yb, 32'd0);
        check_eq("rst_tags", {26'd0, fla | flb, ada | adb}, 32'd0);
        check_eq("rst_exc", {28'd0, exc_a | exc_b}, 32'd0);
        check_eq("rst_in_ready", {30'd0, rdy_a, rdy_b}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("idle_in_ready", {30'd0, rdy_a, rdy_b}, 32'd3);

        // basic divide with tags, plus latency for both radices
        send_x(1'b0, 32'h3F80_0000, 32'h3FC0_0000, 1'b1, 5'd9, 32'h3F2A_AAAB, 4'b0000);
        lat_check(28, 15);

        // reciprocal mode
        send_x(1'b1, 32'h1234_5678, 32'h4040_0000, 1'b0, 5'd3, 32'h3EAA_AAAB, 4'b0000);
        send_x(1'b1, 32'h0000_0000, 32'h4000_0000, 1'b1, 5'd17, 32'h3F00_0000, 4'b0000);

        // specials and range limits
        send_x(1'b0, 32'h40C0_0000, 32'h0000_0000, 1'b0, 5'd1, 32'h7F80_0000, 4'b0100);
        send_x(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 5'd2, 32'h7FC0_0000, 4'b1000);
        send_x(1'b0, 32'h7F7F_FFFF, 32'h3F00_0000, 1'b0, 5'd4, 32'h7F80_0000, 4'b0010);
        send_x(1'b0, 32'h0080_0000, 32'h4000_0000, 1'b1, 5'd8, 32'h0000_0000, 4'b0001);
        send_x(1'b0, 32'hC0C0_0000, 32'h7F80_0000, 1'b0, 5'd5, 32'h8000_0000, 4'b0000);

        // reciprocal-of-significand sweep sample
        send_m(1'b0, 32'h3F80_0000, {1'b0, 8'd127, 23'd0}, 1'b0, 5'd10);
        send_m(1'b0, 32'h3F80_0000, {1'b0, 8'd127, 23'h7FFFFF}, 1'b1, 5'd11);
        for (int i = 0; i < 16; i++) begin
            m = 23'($urandom_range(0, 32'h7F_FFFF));
            send_m(1'b0, 32'h3F80_0000, {1'b0, 8'd127, m}, 1'($urandom), 5'($urandom));
        end

        // random operands, both modes
        for (int i = 0; i < 20; i++) begin
            send_m(1'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom));
        end
        drain();

        // backpressure: result held, second request refused
        out_ready = 1'b0;
        send_x(1'b0, 32'h3F80_0000, 32'h3FC0_0000, 1'b0, 5'd21, 32'h3F2A_AAAB, 4'b0000);
        for (int k = 0; k < 40 && !ova; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("bp_out_valid", 32'(ova), 32'd1);
        x1 = 32'h4080_0000; x2 = 32'h4000_0000; addin = 5'd30; va = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_eq("bp_y", ya, 32'h3F2A_AAAB);
            check_eq("bp_tags", {26'd0, fla, ada}, {26'd0, 1'b0, 5'd21});
            check_eq("bp_in_ready", {30'd0, rdy_a, ova}, 32'd1);
        end
        va = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("bp_no_handoff_accept", 32'(rdy_a), 32'd0);
        @(posedge clk);
        #1;
        check_eq("bp_ov_drop", 32'(ova), 32'd0);
        check_eq("bp_ready_back", 32'(rdy_a), 32'd1);
        drain();

        // reset in the middle of DIV
        send_x(1'b0, 32'h3F80_0000, 32'h4040_0000, 1'b1, 5'd7, 32'h3EAA_AAAB, 4'b0000);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_in_ready_low", {30'd0, rdy_a, rdy_b}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check_eq("rst_ready_after", {30'd0, rdy_a, rdy_b}, 32'd3);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            seen = seen | ova | ovb;
        end
        check_eq("rst_discard", 32'(seen), 32'd0);

        // fresh operation after reset at nominal latency
        send_x(1'b0, 32'h4080_0000, 32'h4000_0000, 1'b1, 5'd30, 32'h4000_0000, 4'b0000);
        lat_check(28, 15);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
